// File: rtl/eth_pcs_rx_sync_ctrl.sv
// 10GBASE-R RX block-alignment sequencer between the RX gearbox and block-sync.
// Turns slip requests into gearbox bitslips, masks settling blocks, bounds each hunt.
module eth_pcs_rx_sync_ctrl #(
  parameter int SLIP_WAIT  = 4,
  parameter int MAX_SLIPS  = 132,
  parameter int FAIL_HOLD  = 1024,
  parameter int W_SLIP_CNT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_slip_req,
  input  logic                  i_rx_lock,
  output logic                  o_bs_valid,
  output logic                  o_bs_reset,
  output logic                  o_gb_slip,
  output logic [W_SLIP_CNT-1:0] o_slip_cnt,
  output logic                  o_rx_status,
  output logic                  o_align_err
);

  localparam int W_WAIT = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int W_FAIL = (FAIL_HOLD > 1) ? $clog2(FAIL_HOLD) : 1;

  typedef enum logic [2:0] {
    ST_RESTART,
    ST_HUNT,
    ST_SLIP_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t                r_state;
  logic [W_SLIP_CNT-1:0] r_slip_cnt;
  logic [W_WAIT-1:0]     r_wait_cnt;
  logic [W_FAIL-1:0]     r_fail_cnt;
  logic                  r_gb_slip;
  logic                  r_rx_status;
  logic                  r_align_err;

  logic w_bs_open;
  logic w_accept;
  logic w_slip_last;
  logic w_wait_done;
  logic w_fail_done;

  // Block-sync only sees blocks while it is allowed to judge alignment.
  assign w_bs_open   = (r_state == ST_HUNT) || (r_state == ST_LOCKED);
  assign w_accept    = i_slip_req & o_bs_valid;
  assign w_slip_last = (r_slip_cnt == W_SLIP_CNT'(MAX_SLIPS - 1));
  assign w_wait_done = (r_wait_cnt == W_WAIT'(SLIP_WAIT - 1));
  assign w_fail_done = (r_fail_cnt == W_FAIL'(FAIL_HOLD - 1));

  assign o_bs_valid  = i_valid & w_bs_open;
  assign o_bs_reset  = (r_state == ST_RESTART);
  assign o_gb_slip   = r_gb_slip;
  assign o_slip_cnt  = r_slip_cnt;
  assign o_rx_status = r_rx_status;
  assign o_align_err = r_align_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RESTART;
      r_slip_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_gb_slip   <= 1'b0;
      r_rx_status <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_gb_slip <= 1'b0;
      case (r_state)
        ST_RESTART: begin
          r_slip_cnt  <= '0;
          r_rx_status <= 1'b0;
          r_state     <= ST_HUNT;
        end

        ST_HUNT: begin
          if (w_accept) begin
            if (w_slip_last) begin
              // Hunt exhausted: the final request is swallowed, no bitslip.
              r_state     <= ST_FAIL;
              r_fail_cnt  <= '0;
              r_align_err <= 1'b1;
            end else begin
              r_state    <= ST_SLIP_WAIT;
              r_slip_cnt <= r_slip_cnt + W_SLIP_CNT'(1);
              r_wait_cnt <= '0;
              r_gb_slip  <= 1'b1;
            end
          end else if (i_rx_lock) begin
            r_state     <= ST_LOCKED;
            r_slip_cnt  <= '0;
            r_align_err <= 1'b0;
            r_rx_status <= 1'b1;
          end
        end

        ST_SLIP_WAIT: begin
          // Settling is measured in gearbox beats, not clocks.
          if (i_valid) begin
            if (w_wait_done) begin
              r_state <= ST_HUNT;
            end else begin
              r_wait_cnt <= r_wait_cnt + W_WAIT'(1);
            end
          end
        end

        ST_LOCKED: begin
          if (w_accept) begin
            r_state     <= ST_SLIP_WAIT;
            r_slip_cnt  <= W_SLIP_CNT'(1);
            r_wait_cnt  <= '0;
            r_gb_slip   <= 1'b1;
            r_rx_status <= 1'b0;
          end else if (!i_rx_lock) begin
            r_state     <= ST_HUNT;
            r_rx_status <= 1'b0;
          end
        end

        ST_FAIL: begin
          if (w_fail_done) begin
            r_state <= ST_RESTART;
          end else begin
            r_fail_cnt <= r_fail_cnt + W_FAIL'(1);
          end
        end

        default: begin
          r_state     <= ST_RESTART;
          r_rx_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_sync_ctrl.sv
// Directed bench for eth_pcs_rx_sync_ctrl: stimulus queues expected slip/restart
// pulses with their cycle stamps; a negedge monitor pops and compares them.
module tb_eth_pcs_rx_sync_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       i_slip_req;
  logic       i_rx_lock;
  logic       o_bs_valid;
  logic       o_bs_reset;
  logic       o_gb_slip;
  logic [7:0] o_slip_cnt;
  logic       o_rx_status;
  logic       o_align_err;

  eth_pcs_rx_sync_ctrl #(
    .SLIP_WAIT(4), .MAX_SLIPS(132), .FAIL_HOLD(1024), .W_SLIP_CNT(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_slip_req(i_slip_req),
    .i_rx_lock(i_rx_lock), .o_bs_valid(o_bs_valid), .o_bs_reset(o_bs_reset),
    .o_gb_slip(o_gb_slip), .o_slip_cnt(o_slip_cnt), .o_rx_status(o_rx_status),
    .o_align_err(o_align_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t gb_q[$];
  int   bsr_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  // Accept one slip in HUNT and confirm block-sync is masked for 4 valid beats.
  task automatic do_slip(input int exp_cnt);
    i_slip_req = 1'b1;
    gb_q.push_back('{cyc: cyc + 1, cnt: exp_cnt});
    tick();
    i_slip_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("mask_during_wait", o_bs_valid, 0);
      tick();
    end
    #1 chk("unmask_after_wait", o_bs_valid, 1);
  endtask

  // Monitor: every gearbox slip and block-sync restart must match a queued expectation.
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (!i_reset) begin
      if (o_gb_slip) begin
        if (gb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gb_slip_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = gb_q.pop_front();
          chk("gb_slip_cycle", cyc, e.cyc);
          chk("gb_slip_cnt", o_slip_cnt, e.cnt);
        end
      end else if (gb_q.size() != 0 && gb_q[0].cyc < cyc) begin
        e = gb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL gb_slip_missing: no pulse observed, expected at cycle %0d", e.cyc);
      end

      if (o_bs_reset) begin
        if (bsr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bs_reset_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          chk("bs_reset_cycle", cyc, bsr_q.pop_front());
        end
      end else if (bsr_q.size() != 0 && bsr_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL bs_reset_missing: no pulse observed, expected at cycle %0d", bsr_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int c;
    int f;
    i_reset = 1'b1; i_valid = 1'b1; i_slip_req = 1'b0; i_rx_lock = 1'b0;

    // 1: reset state, restart pulse, hunt, lock after 64 beats
    repeat (3) tick();
    chk("rst_bs_reset", o_bs_reset, 1);
    chk("rst_gb_slip", o_gb_slip, 0);
    chk("rst_slip_cnt", o_slip_cnt, 0);
    chk("rst_rx_status", o_rx_status, 0);
    chk("rst_align_err", o_align_err, 0);
    chk("rst_bs_valid", o_bs_valid, 0);
    i_reset = 1'b0;
    bsr_q.push_back(cyc);
    tick();
    chk("hunt_bs_valid", o_bs_valid, 1);
    chk("hunt_bs_reset", o_bs_reset, 0);
    repeat (63) tick();
    i_rx_lock = 1'b1;
    #1 chk("pre_lock_rx_status", o_rx_status, 0);
    tick();
    chk("lock_rx_status", o_rx_status, 1);
    chk("lock_slip_cnt", o_slip_cnt, 0);

    // 2: three slips from HUNT
    i_rx_lock = 1'b0;
    tick();
    chk("unlock_rx_status", o_rx_status, 0);
    do_slip(1);
    do_slip(2);
    do_slip(3);
    chk("three_slip_cnt", o_slip_cnt, 3);

    // 3: requests ignored during settle, idle cycles do not count
    i_slip_req = 1'b1;
    gb_q.push_back('{cyc: cyc + 1, cnt: 4});
    tick();
    for (int k = 0; k < 7; k++) begin
      i_valid = (k % 2 == 0);
      #1 chk("mask_toggle_valid", o_bs_valid, 0);
      tick();
    end
    i_slip_req = 1'b0;
    i_valid = 1'b1;
    #1 chk("unmask_after_toggle", o_bs_valid, 1);
    chk("toggle_slip_cnt", o_slip_cnt, 4);

    // 4: exhaust a fresh hunt: 131 slips, FAIL, hold 1024, restart
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    bsr_q.push_back(cyc);
    tick();
    c = cyc;
    i_slip_req = 1'b1;
    for (int j = 0; j < 131; j++) gb_q.push_back('{cyc: c + 1 + 5 * j, cnt: j + 1});
    f = c + 656;
    tick_until(f - 1);
    chk("pre_fail_align_err", o_align_err, 0);
    tick();
    chk("fail_align_err", o_align_err, 1);
    chk("fail_slip_cnt_sat", o_slip_cnt, 131);
    chk("fail_bs_valid", o_bs_valid, 0);
    i_slip_req = 1'b0;
    bsr_q.push_back(f + 1024);
    tick_until(f + 1023);
    chk("fail_hold_no_restart", o_bs_reset, 0);
    tick();
    chk("restart_after_hold", o_bs_reset, 1);
    tick();
    chk("rehunt_bs_valid", o_bs_valid, 1);
    chk("rehunt_slip_cnt", o_slip_cnt, 0);
    chk("rehunt_align_err", o_align_err, 1);

    // 5: lock clears error; lock drop with slip in same cycle
    i_rx_lock = 1'b1;
    tick();
    chk("relock_align_err", o_align_err, 0);
    chk("relock_rx_status", o_rx_status, 1);
    i_rx_lock = 1'b0;
    i_slip_req = 1'b1;
    gb_q.push_back('{cyc: cyc + 1, cnt: 1});
    tick();
    chk("locked_slip_cnt", o_slip_cnt, 1);
    chk("locked_slip_rx_status", o_rx_status, 0);
    i_slip_req = 1'b0;
    repeat (4) tick();
    chk("locked_slip_unmask", o_bs_valid, 1);
    i_rx_lock = 1'b1;
    tick();
    chk("lock_regain_align_err", o_align_err, 0);
    chk("lock_regain_rx_status", o_rx_status, 1);
    chk("lock_regain_slip_cnt", o_slip_cnt, 0);

    // 6: async reset while the bitslip pulse is high
    i_slip_req = 1'b1;
    gb_q.push_back('{cyc: cyc + 1, cnt: 1});
    tick();
    i_slip_req = 1'b0;
    chk("abort_pulse_high", o_gb_slip, 1);
    @(negedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    chk("abort_gb_slip", o_gb_slip, 0);
    chk("abort_bs_reset", o_bs_reset, 1);
    chk("abort_slip_cnt", o_slip_cnt, 0);
    chk("abort_rx_status", o_rx_status, 0);
    tick();
    tick();
    i_reset = 1'b0;
    i_rx_lock = 1'b0;
    bsr_q.push_back(cyc);
    repeat (10) tick();
    chk("post_abort_bs_valid", o_bs_valid, 1);
    chk("post_abort_slip_cnt", o_slip_cnt, 0);

    chk("gb_queue_drained", gb_q.size(), 0);
    chk("bsr_queue_drained", bsr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
